// File: rtl/timer_irq_ctrl.sv
// Memory-mapped timer/IRQ controller: TH reload, TL counter, TCON (EN/IE/ST), prescaled ticks, level irq.
// Zero-latency combinational reads, writes commit at clk edge, no wait states; TIMER_OVF_COUNT_EN adds OVF counter.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        sel,
  input  logic        kernel_mode,
  output logic        irq
);

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} state_t;

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  state_t      state_q, state_d;
  logic        run;
  logic [15:0] presc_q;
  logic [31:0] th_q, tl_q;
  logic        en_q, ie_q, st_q;
  logic        hit, wr_th, wr_tl, wr_tcon;
  logic        en_d, tick, ovf_evt;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign sel     = hit;
  assign wr_th   = wr & hit & (addr[3:2] == 2'd0);
  assign wr_tl   = wr & hit & (addr[3:2] == 2'd1);
  assign wr_tcon = wr & hit & (addr[3:2] == 2'd2);

  // State follows the EN value being committed, so a clearing write still lets this cycle's tick land.
  assign en_d = wr_tcon ? wdata[0] : en_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= STOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (en_d)  state_d = RUN;
      RUN:     if (!en_d) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  always_comb begin
    run = (state_q == RUN);
  end

  assign tick    = run & (presc_q == PRE_LAST);
  // A bus write to TL pre-empts both the increment and the overflow.
  assign ovf_evt = tick & ~wr_tl & (tl_q == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    presc_q <= 16'h0;
    else if (!run) presc_q <= 16'h0;
    else if (tick) presc_q <= 16'h0;
    else           presc_q <= presc_q + 16'h1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q <= 32'h0;
      tl_q <= 32'h0;
    end else begin
      if (wr_th) th_q <= wdata;
      if (wr_tl)        tl_q <= wdata;
      else if (ovf_evt) tl_q <= th_q;
      else if (tick)    tl_q <= tl_q + 32'h1;
    end
  end

  // Hardware set of ST beats a same-cycle software clear so no overflow is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q <= 1'b0;
      ie_q <= 1'b0;
      st_q <= 1'b0;
    end else begin
      if (wr_tcon) begin
        en_q <= wdata[0];
        ie_q <= wdata[1];
      end
      if (ovf_evt)                 st_q <= 1'b1;
      else if (wr_tcon & wdata[2]) st_q <= 1'b0;
    end
  end

`ifdef TIMER_OVF_COUNT_EN
  logic [31:0] ovf_cnt_q;
  logic        wr_ovf;

  assign wr_ovf = wr & hit & (addr[3:2] == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      ovf_cnt_q <= 32'h0;
    else if (wr_ovf)                 ovf_cnt_q <= 32'h0;
    else if (ovf_evt & ~&ovf_cnt_q)  ovf_cnt_q <= ovf_cnt_q + 32'h1;
  end
`endif

  always_comb begin
    rdata = 32'h0;
    if (rd & hit) begin
      case (addr[3:2])
        2'd0:    rdata = th_q;
        2'd1:    rdata = tl_q;
        2'd2:    rdata = {29'h0, st_q, ie_q, en_q};
`ifdef TIMER_OVF_COUNT_EN
        2'd3:    rdata = ovf_cnt_q;
`else
        2'd3:    rdata = 32'h0;
`endif
        default: rdata = 32'h0;
      endcase
    end
  end

  assign irq = st_q & ie_q & en_q & ~kernel_mode;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Randomized scoreboard bench for timer_irq_ctrl: two instances (PRESCALE 1 and 4) share one bus and are
// compared each cycle against a behavioural model of the register file; TIMER_OVF_COUNT_EN is honoured.
module tb_timer_irq_ctrl;

  localparam logic [31:0] BASE   = 32'h40000000;
  localparam logic [31:0] A_TH   = BASE + 32'h0;
  localparam logic [31:0] A_TL   = BASE + 32'h4;
  localparam logic [31:0] A_TCON = BASE + 32'h8;
  localparam logic [31:0] A_OVF  = BASE + 32'hC;
  localparam logic [31:0] ALLF   = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, rd, wr, kernel_mode;
  logic [31:0] addr, wdata;
  logic [31:0] rdata_a, rdata_b;
  logic        sel_a, sel_b, irq_a, irq_b;

  always #5 clk = ~clk;

  timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_a), .sel(sel_a), .kernel_mode(kernel_mode), .irq(irq_a));

  timer_irq_ctrl #(.BASE_ADDR(BASE), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(rst_n), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata_b), .sel(sel_b), .kernel_mode(kernel_mode), .irq(irq_b));

  typedef struct {
    bit          rd;
    bit          sel;
    logic [31:0] rdat_a;
    logic [31:0] rdat_b;
    bit          irq_a;
    bit          irq_b;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: index 0 is the PRESCALE=1 instance, index 1 the PRESCALE=4 instance.
  logic [31:0] m_th[2], m_tl[2], m_ovf[2];
  bit          m_en[2], m_ie[2], m_st[2];
  int unsigned m_run[2];

  function automatic int unsigned pre(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_th[i] = 0; m_tl[i] = 0; m_ovf[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0; m_run[i] = 0;
    end
  endfunction

  function automatic bit in_win(logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h10);
  endfunction

  function automatic logic [31:0] model_read(int i, logic [31:0] a);
    int idx;
    if (!in_win(a)) return 32'h0;
    idx = int'((a - BASE) / 4);
    if (idx == 0) return m_th[i];
    if (idx == 1) return m_tl[i];
    if (idx == 2) return (m_st[i] ? 32'd4 : 32'd0) + (m_ie[i] ? 32'd2 : 32'd0) + (m_en[i] ? 32'd1 : 32'd0);
`ifdef TIMER_OVF_COUNT_EN
    return m_ovf[i];
`else
    return 32'h0;
`endif
  endfunction

  function automatic void model_step(int i, bit w, logic [31:0] a, logic [31:0] d);
    int          idx;
    bit          tick, ov;
    logic [31:0] next_tl;
    idx     = in_win(a) ? int'((a - BASE) / 4) : -1;
    // Ticks fall on the last cycle of every PRESCALE-long stretch of running time.
    tick    = m_en[i] && ((m_run[i] % pre(i)) == pre(i) - 1);
    ov      = 0;
    next_tl = m_tl[i];
    if (w && idx == 1) next_tl = d;
    else if (tick) begin
      if (m_tl[i] == ALLF) begin next_tl = m_th[i]; ov = 1; end
      else next_tl = m_tl[i] + 1;
    end
    m_run[i] = m_en[i] ? m_run[i] + 1 : 0;
    if (w && idx == 0) m_th[i] = d;
    m_tl[i] = next_tl;
    if (ov) m_st[i] = 1;
    else if (w && idx == 2 && d[2]) m_st[i] = 0;
    if (w && idx == 2) begin m_en[i] = d[0]; m_ie[i] = d[1]; end
    if (w && idx == 3) m_ovf[i] = 0;
    else if (ov && m_ovf[i] != ALLF) m_ovf[i] = m_ovf[i] + 1;
  endfunction

  task automatic cyc(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit k, input bit rst = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; rd = r; wr = w; addr = a; wdata = d; kernel_mode = k;
    if (!rst) model_reset();
    e.rd     = r;
    e.sel    = in_win(a);
    e.rdat_a = r ? model_read(0, a) : 32'h0;
    e.rdat_b = r ? model_read(1, a) : 32'h0;
    e.irq_a  = m_st[0] && m_ie[0] && m_en[0] && !k;
    e.irq_b  = m_st[1] && m_ie[1] && m_en[1] && !k;
    exp_q.push_back(e);
    if (rst) begin
      model_step(0, w, a, d);
      model_step(1, w, a, d);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUTs present irq/sel, and rdata when rd is strobed.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("irq_p1", {31'h0, irq_a}, {31'h0, e.irq_a});
      chk("irq_p4", {31'h0, irq_b}, {31'h0, e.irq_b});
      chk("sel", {30'h0, sel_b, sel_a}, {30'h0, e.sel, e.sel});
      if (e.rd) begin
        chk("rdata_p1", rdata_a, e.rdat_a);
        chk("rdata_p4", rdata_b, e.rdat_b);
      end
    end
  end

  function automatic logic [31:0] pick_data();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(5))
      0: return ALLF;
      1: return 32'hFFFF_FFFE;
      2: return 32'hFFFF_FFFC;
      3: return 32'($urandom_range(7));
      default: return v;
    endcase
  endfunction

  initial begin
    logic [31:0] a, d, rnd;
    bit          r, w, k, rs;
    rst_n = 1'b0; rd = 0; wr = 0; addr = 0; wdata = 0; kernel_mode = 0;
    model_reset();

    // Reset and decode, including a hit on TCON and a miss just past the window.
    cyc(1, 0, A_TCON, 0, 0, 0);
    cyc(1, 0, BASE + 32'h10, 0, 0, 0);
    cyc(1, 0, A_TL, 0, 0);
    cyc(1, 0, BASE + 32'h10, 0, 0);

    // Basic overflow from FFFFFFFC with TH=FFFFFFFC.
    cyc(0, 1, A_TH, 32'hFFFF_FFFC, 0);
    cyc(0, 1, A_TL, 32'hFFFF_FFFC, 0);
    cyc(0, 1, A_TCON, 32'h3, 0);
    repeat (8) cyc(1, 0, A_TL, 0, 0);

    // Kernel masking, then clear ST with TCON=7.
    cyc(1, 0, A_TCON, 0, 1);
    cyc(1, 0, A_TCON, 0, 1);
    cyc(1, 0, A_TCON, 0, 0);
    cyc(0, 1, A_TCON, 32'h7, 0);
    cyc(1, 0, A_TCON, 0, 0);

    // Write to TL on an overflowing tick, and TCON=7 on an overflow.
    cyc(0, 1, A_TCON, 32'h0, 0);
    cyc(0, 1, A_TL, ALLF - 1, 0);
    cyc(0, 1, A_TCON, 32'h3, 0);
    cyc(1, 0, A_TL, 0, 0);
    cyc(1, 1, A_TL, 32'h5, 0);
    cyc(1, 0, A_TCON, 0, 0);
    cyc(0, 1, A_TL, ALLF - 1, 0);
    cyc(1, 0, A_TL, 0, 0);
    cyc(1, 1, A_TCON, 32'h7, 0);
    cyc(1, 0, A_TCON, 0, 0);

    // Prescaled counting from 0, then stop and hold.
    cyc(0, 1, A_TCON, 32'h0, 0);
    cyc(0, 1, A_TL, 32'h0, 0);
    cyc(0, 1, A_TCON, 32'h1, 0);
    repeat (8) cyc(1, 0, A_TL, 0, 0);
    cyc(1, 1, A_TCON, 32'h0, 0);
    repeat (4) cyc(1, 0, A_TL, 0, 0);

    // Back-to-back overflows with TH=TL=FFFFFFFF, then clear OVF.
    cyc(0, 1, A_TH, ALLF, 0);
    cyc(0, 1, A_TL, ALLF, 0);
    cyc(0, 1, A_TCON, 32'h3, 0);
    repeat (5) cyc(1, 0, A_OVF, 0, 0);
    cyc(1, 1, A_OVF, 32'h0, 0);
    cyc(1, 0, A_OVF, 0, 0);

    // Reset asserted mid-count, then released.
    cyc(1, 0, A_TL, 0, 0, 0);
    cyc(1, 0, A_TCON, 0, 0, 0);
    cyc(1, 0, A_TL, 0, 0);
    cyc(1, 0, A_TCON, 0, 0);

    for (int n = 0; n < 4000; n++) begin
      rnd = $urandom;
      case ($urandom_range(9))
        8:       a = BASE + 32'h10 + 32'($urandom_range(15));
        9:       a = rnd;
        default: a = BASE + 32'($urandom_range(15));
      endcase
      d = pick_data();
      if (in_win(a) && ((a - BASE) / 4) == 2) begin
        d[0] = ($urandom_range(3) != 0);
        d[1] = ($urandom_range(1) != 0);
        d[2] = ($urandom_range(2) == 0);
      end
      w  = ($urandom_range(99) < 25);
      r  = ($urandom_range(1) != 0);
      k  = ($urandom_range(4) == 0);
      rs = !((n % 700) == 350);
      cyc(r, w, a, d, k, rs);
    end

    cyc(0, 0, 32'h0, 32'h0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
